// File: rtl/uart_program_loader.sv
`default_nettype none
// ============================================================================
// uart_program_loader : boot loader, UART 8N1 image -> program_memory writes,
// holds the core in reset until a full image arrives. Option: LOADER_CHECKSUM_EN
// Revision: 1.0
// ============================================================================
module uart_program_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MEM_WORDS    = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        io_rx,
  output logic [31:0] mem_address,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_data,
  output logic        cpu_reset_n,
  output logic        load_done,
  output logic        load_error
);

  localparam int                 c_cnt_w     = $clog2(CLKS_PER_BIT);
  localparam logic [c_cnt_w-1:0] c_full_max  = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_cnt_w-1:0] c_half_max  = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0]        c_mem_words = 32'(MEM_WORDS);

  // ---------------------------------------------------------------- receiver
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  rx_state_t          r_rx_state, w_rx_next;
  logic               r_rx_meta, r_rx_sync, r_rx_prev;
  logic [c_cnt_w-1:0] r_clk_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic               r_byte_valid;
  logic [7:0]         r_byte_data;
  logic               r_frame_err;
  logic               w_half_tick, w_full_tick;

  assign w_half_tick = (r_clk_cnt == c_half_max);
  assign w_full_tick = (r_clk_cnt == c_full_max);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rx_state <= RX_IDLE;
    else          r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (r_rx_prev && !r_rx_sync) w_rx_next = RX_START;
      RX_START: if (w_half_tick) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_full_tick && (r_bit_idx == 3'd7)) w_rx_next = RX_STOP;
      RX_STOP:  if (w_full_tick) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_meta    <= 1'b1;
      r_rx_sync    <= 1'b1;
      r_rx_prev    <= 1'b1;
      r_clk_cnt    <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_byte_data  <= '0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_meta    <= io_rx;
      r_rx_sync    <= r_rx_meta;
      r_rx_prev    <= r_rx_sync;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          r_clk_cnt <= '0;
          r_bit_idx <= '0;
        end
        RX_START: r_clk_cnt <= w_half_tick ? '0 : r_clk_cnt + 1'b1;
        RX_DATA: begin
          if (w_full_tick) begin
            r_clk_cnt <= '0;
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (w_full_tick) begin
            r_clk_cnt <= '0;
            if (r_rx_sync) begin
              r_byte_valid <= 1'b1;
              r_byte_data  <= r_shift;
            end else begin
              r_frame_err  <= 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: r_clk_cnt <= '0;
      endcase
    end
  end

  // ------------------------------------------------------------------ loader
  typedef enum logic [2:0] {
    LD_LEN0  = 3'd0,
    LD_LEN1  = 3'd1,
    LD_DATA  = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    LD_CSUM  = 3'd3,
`endif
    LD_DONE  = 3'd4,
    LD_ERROR = 3'd5
  } ld_state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam ld_state_t c_after_payload = LD_CSUM;
`else
  localparam ld_state_t c_after_payload = LD_DONE;
`endif

  ld_state_t   r_ld_state, w_ld_next;
  logic [15:0] r_count;
  logic [15:0] r_word_idx;
  logic [1:0]  r_byte_idx;
  logic [23:0] r_word_buf;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_data;
  logic        r_mem_we;
  logic        r_cpu_rst_n;
  logic        r_done;
  logic        r_error;
  logic [15:0] w_len;
  logic        w_last_word;
  logic        w_terminal;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  r_csum;
`endif

  assign w_len       = {r_byte_data, r_count[7:0]};
  assign w_last_word = ((r_word_idx + 16'd1) == r_count);
  assign w_terminal  = (r_ld_state == LD_DONE) || (r_ld_state == LD_ERROR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_ld_state <= LD_LEN0;
    else          r_ld_state <= w_ld_next;
  end

  always_comb begin
    w_ld_next = r_ld_state;
    if (r_frame_err && !w_terminal) begin
      w_ld_next = LD_ERROR;
    end else if (r_byte_valid) begin
      case (r_ld_state)
        LD_LEN0: w_ld_next = LD_LEN1;
        LD_LEN1: begin
          if ({16'd0, w_len} > c_mem_words) w_ld_next = LD_ERROR;
          else if (w_len == 16'd0)          w_ld_next = c_after_payload;
          else                              w_ld_next = LD_DATA;
        end
        LD_DATA: if ((r_byte_idx == 2'd3) && w_last_word) w_ld_next = c_after_payload;
`ifdef LOADER_CHECKSUM_EN
        LD_CSUM: w_ld_next = (r_byte_data == r_csum) ? LD_DONE : LD_ERROR;
`endif
        default: w_ld_next = r_ld_state;
      endcase
    end
  end

  // Address/data only change on a write, so they hold between strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count     <= '0;
      r_word_idx  <= '0;
      r_byte_idx  <= '0;
      r_word_buf  <= '0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_mem_we    <= 1'b0;
      r_cpu_rst_n <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_csum      <= '0;
`endif
    end else begin
      r_mem_we    <= 1'b0;
      r_cpu_rst_n <= (r_ld_state == LD_DONE);
      r_done      <= (r_ld_state == LD_DONE);
      r_error     <= (r_ld_state == LD_ERROR);
      if (r_byte_valid) begin
        case (r_ld_state)
          LD_LEN0: r_count[7:0] <= r_byte_data;
          LD_LEN1: begin
            r_count[15:8] <= r_byte_data;
            r_word_idx    <= '0;
            r_byte_idx    <= '0;
          end
          LD_DATA: begin
            r_byte_idx <= r_byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            r_csum     <= r_csum ^ r_byte_data;
`endif
            if (r_byte_idx == 2'd3) begin
              r_mem_we   <= 1'b1;
              r_mem_addr <= 32'({r_word_idx, 2'b00});
              r_mem_data <= {r_byte_data, r_word_buf};
              r_word_idx <= r_word_idx + 16'd1;
            end else begin
              r_word_buf <= {r_byte_data, r_word_buf[23:8]};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_address      = r_mem_addr;
  assign mem_write_enable = r_mem_we;
  assign mem_write_data   = r_mem_data;
  assign cpu_reset_n      = r_cpu_rst_n;
  assign load_done        = r_done;
  assign load_error       = r_error;

endmodule
`default_nettype wire

// File: tb/tb_uart_program_loader.sv
`timescale 1ns/1ps
`default_nettype none
// Self-checking bench for uart_program_loader: directed images, image-level
// model producing expected writes and terminal status.
module tb_uart_program_loader;

  localparam int C  = 16;
  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        io_rx = 1'b1;
  logic [31:0] mem_address, mem_write_data;
  logic        mem_write_enable, cpu_reset_n, load_done, load_error;

  uart_program_loader #(.CLKS_PER_BIT(C), .MEM_WORDS(MW)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .io_rx            (io_rx),
    .mem_address      (mem_address),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .cpu_reset_n      (cpu_reset_n),
    .load_done        (load_done),
    .load_error       (load_error)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          last_we_cyc = 0;
  int          done_rise_cyc = 0;
  logic        done_prev = 1'b0;
  logic [1:0]  rel_prev = 2'b00;
  logic [7:0]  tx_q[$];
  logic [31:0] exp_addr_q[$], exp_data_q[$];
  logic [31:0] log_addr[$], log_data[$];
  logic        exp_done, exp_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Compare process: every strobe is matched against the model's write list.
  always @(negedge clk) begin
    cyc++;
    if (reset_n) begin
      if (mem_write_enable) begin
        log_addr.push_back(mem_address);
        log_data.push_back(mem_write_data);
        last_we_cyc = cyc;
        if (exp_addr_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write",
                   mem_address, mem_write_data);
        end else begin
          check("write_addr", mem_address, exp_addr_q.pop_front());
          check("write_data", mem_write_data, exp_data_q.pop_front());
        end
      end
      if (load_done && !done_prev) done_rise_cyc = cyc;
      if ({cpu_reset_n, load_done} != rel_prev)
        check("cpu_reset_n_tracks_done", {31'd0, cpu_reset_n}, {31'd0, load_done});
      done_prev = load_done;
      rel_prev  = {cpu_reset_n, load_done};
    end else begin
      done_prev = 1'b0;
      rel_prev  = 2'b00;
    end
  end

  // Image-level model: expected writes and terminal status from the byte stream.
  task automatic model_image(input int bad_idx);
    int n, sz, term;
    logic [7:0] x;
    exp_addr_q.delete();
    exp_data_q.delete();
    sz = (bad_idx >= 0) ? bad_idx : tx_q.size();
    exp_done = 1'b0;
    exp_err  = (bad_idx >= 0);
    if (sz < 2) return;
    n = int'({tx_q[1], tx_q[0]});
    if (n > MW) begin
      exp_err = 1'b1;
      return;
    end
    x = 8'h00;
    for (int w = 0; w < n; w++) begin
      if (5 + 4 * w < sz) begin
        exp_addr_q.push_back(32'(4 * w));
        exp_data_q.push_back({tx_q[5+4*w], tx_q[4+4*w], tx_q[3+4*w], tx_q[2+4*w]});
      end
    end
    for (int i = 2; i < 2 + 4 * n && i < sz; i++) x = x ^ tx_q[i];
    term = 2 + 4 * n;
`ifdef LOADER_CHECKSUM_EN
    term = term + 1;
`endif
    if (sz >= term) begin
      exp_done = 1'b1;
      exp_err  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      if (tx_q[term-1] != x) begin
        exp_done = 1'b0;
        exp_err  = 1'b1;
      end
`endif
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    io_rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      io_rx = b[i];
      repeat (C) @(negedge clk);
    end
    io_rx = stop;
    repeat (C) @(negedge clk);
    io_rx = 1'b1;
  endtask

  task automatic send_range(input int lo, input int hi, input int bad_idx);
    for (int i = lo; i < hi; i++) begin
      send_byte(tx_q[i], (i != bad_idx));
      if (i == bad_idx) repeat (2 * C) @(negedge clk);
    end
  endtask

  task automatic finish_checks(input string tag);
    repeat (2 * C) @(negedge clk);
    check({tag, "_load_done"},   {31'd0, load_done},   {31'd0, exp_done});
    check({tag, "_load_error"},  {31'd0, load_error},  {31'd0, exp_err});
    check({tag, "_cpu_reset_n"}, {31'd0, cpu_reset_n}, {31'd0, exp_done});
    check({tag, "_writes_missing"}, 32'(exp_addr_q.size()), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_addr"}, mem_address, 32'd0);
    check({tag, "_data"}, mem_write_data, 32'd0);
    check({tag, "_flags"}, {27'd0, mem_write_enable, cpu_reset_n, load_done, load_error, 1'b0}, 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    io_rx   = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    exp_addr_q.delete();
    exp_data_q.delete();
    log_addr.delete();
    log_data.delete();
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    // Two-word load
    do_reset();
    tx_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    tx_q.push_back(8'hB0);
`endif
    model_image(-1);
    send_range(0, tx_q.size(), -1);
    finish_checks("two_word");
    check("two_word_nwrites", 32'(log_addr.size()), 32'd2);
    check("two_word_addr0", log_addr[0], 32'h0);
    check("two_word_data0", log_data[0], 32'h00100513);
    check("two_word_addr1", log_addr[1], 32'h4);
    check("two_word_data1", log_data[1], 32'h00200593);
    check("two_word_done_flag", {31'd0, load_done}, 32'd1);
`ifndef LOADER_CHECKSUM_EN
    check("done_after_last_write", 32'(done_rise_cyc - last_we_cyc), 32'd1);
`endif

    // Zero count
    do_reset();
    tx_q = '{8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    tx_q.push_back(8'h00);
`endif
    model_image(-1);
    send_range(0, 2, -1);
`ifdef LOADER_CHECKSUM_EN
    repeat (2 * C) @(negedge clk);
    check("zero_csum_pending", {31'd0, load_done}, 32'd0);
    send_range(2, 3, -1);
`endif
    finish_checks("zero");
    check("zero_nwrites", 32'(log_addr.size()), 32'd0);

    // Oversize count
    do_reset();
    tx_q = '{8'h05, 8'h00};
    for (int i = 0; i < 20; i++) tx_q.push_back(8'(i * 7 + 1));
    model_image(-1);
    send_range(0, 2, -1);
    repeat (C) @(negedge clk);
    check("oversize_err_early", {31'd0, load_error}, 32'd1);
    check("oversize_core_held", {31'd0, cpu_reset_n}, 32'd0);
    send_range(2, tx_q.size(), -1);
    finish_checks("oversize");
    check("oversize_nwrites", 32'(log_addr.size()), 32'd0);

    // Framing error inside payload
    do_reset();
    tx_q = '{8'h01, 8'h00, 8'hAB, 8'hCD, 8'hEF, 8'h12};
    model_image(2);
    send_range(0, tx_q.size(), 2);
    finish_checks("frame");
    check("frame_err_flag", {31'd0, load_error}, 32'd1);
    check("frame_nwrites", 32'(log_addr.size()), 32'd0);

    // Short glitch on idle line, then a valid zero-count image
    do_reset();
    io_rx = 1'b0;
    repeat (3) @(negedge clk);
    io_rx = 1'b1;
    repeat (4 * C) @(negedge clk);
    tx_q = '{8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    tx_q.push_back(8'h00);
`endif
    model_image(-1);
    send_range(0, tx_q.size(), -1);
    finish_checks("glitch");

    // Word packing (and checksum match when compiled in)
    do_reset();
    tx_q = '{8'h01, 8'h00, 8'hAA, 8'h55, 8'h0F, 8'hF0};
`ifdef LOADER_CHECKSUM_EN
    tx_q.push_back(8'h00);
`endif
    model_image(-1);
    send_range(0, tx_q.size(), -1);
    finish_checks("pack");
    check("pack_data", log_data[0], 32'hF00F55AA);

`ifdef LOADER_CHECKSUM_EN
    do_reset();
    tx_q = '{8'h01, 8'h00, 8'hAA, 8'h55, 8'h0F, 8'hF0, 8'h01};
    model_image(-1);
    send_range(0, tx_q.size(), -1);
    finish_checks("csum_bad");
    check("csum_bad_err", {31'd0, load_error}, 32'd1);
    check("csum_bad_data", log_data[0], 32'hF00F55AA);
`endif

    // Maximum count
    do_reset();
    tx_q = '{8'h04, 8'h00};
    for (int i = 0; i < 16; i++) tx_q.push_back(8'(8'h11 * (i + 1)));
`ifdef LOADER_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      for (int i = 2; i < 18; i++) x = x ^ tx_q[i];
      tx_q.push_back(x);
    end
`endif
    model_image(-1);
    send_range(0, tx_q.size(), -1);
    finish_checks("max");
    check("max_last_addr", log_addr[3], 32'hC);

    // Reset mid-load: 3 of 4 bytes of word 1
    do_reset();
    tx_q = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    model_image(-1);
    send_range(0, tx_q.size(), -1);
    repeat (C) @(negedge clk);
    check("midload_word0", log_data[0], 32'h44332211);
    #2 reset_n = 1'b0;
    #1 check_outputs_zero("async_reset");
    check("midload_writes_missing", 32'(exp_addr_q.size()), 32'd0);
    @(negedge clk);
    do_reset();
    tx_q = '{8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef LOADER_CHECKSUM_EN
    tx_q.push_back(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
`endif
    model_image(-1);
    send_range(0, tx_q.size(), -1);
    finish_checks("reload");
    check("reload_addr", log_addr[0], 32'h0);
    check("reload_data", log_data[0], 32'hEFBEADDE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
